nano_uart_monitor: RTL

//  Downstream consumer of the Nano_mcsys_4Tiny debug taps: state byte, flags byte and 32-bit R word.

---
 rtl/nano_uart_monitor_pkg.sv | 23 ++
 rtl/nano_uart_monitor_uart_tx_byte.sv | 81 ++++++++
 rtl/nano_uart_monitor.sv | 109 ++++++++++
 3 files changed

// File: rtl/nano_uart_monitor_pkg.sv
// rtl/nano_uart_monitor_pkg.sv - shared encodings, defaults and checksum for the UART debug monitor
package nano_uart_monitor_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } tx_state_t;

   localparam logic [7:0] MON_HEADER           = 8'hA5;
   localparam int         MON_FRAME_BYTES      = 8;
   // 163 clocks per bit at 1.5625 MHz gives 9586 baud, within 0.15% of 9600
   localparam int         DEFAULT_CLKS_PER_BIT = 163;
   localparam int         DEFAULT_AUTO_PERIOD  = 156250;

   function automatic logic [7:0] frame_chk(input logic [7:0]  state_b,
                                            input logic [7:0]  flags_b,
                                            input logic [31:0] r_w);
      return state_b ^ flags_b ^ r_w[7:0] ^ r_w[15:8] ^ r_w[23:16] ^ r_w[31:24];
   endfunction

endpackage

// File: rtl/nano_uart_monitor_uart_tx_byte.sv
// rtl/nano_uart_monitor_uart_tx_byte.sv - 8N1 byte transmitter; a load at stop-bit end chains the next byte with no gap
module uart_tx_byte
   import nano_uart_monitor_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       load,
   input  logic [7:0] data,
   output logic       tx,
   output logic       done
);

   localparam int            CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

   tx_state_t     state;
   tx_state_t     state_next;
   logic [CW-1:0] cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shreg;
   logic          bit_end;
   logic          take;

   assign bit_end = (cnt == CNT_LAST);
   assign take    = load && ((state == ST_IDLE) || ((state == ST_STOP) && bit_end));

   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:  if (load) state_next = ST_START;
         ST_START: if (bit_end) state_next = ST_DATA;
         ST_DATA:  if (bit_end && (bit_idx == 3'd7)) state_next = ST_STOP;
         ST_STOP:  if (bit_end) state_next = load ? ST_START : ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      tx   = 1'b1;
      done = 1'b0;
      case (state)
         ST_START: tx = 1'b0;
         ST_DATA:  tx = shreg[0];
         ST_STOP:  done = bit_end;
         default:  tx = 1'b1;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         cnt     <= '0;
         bit_idx <= '0;
         shreg   <= '0;
      end else if (take) begin
         cnt     <= '0;
         bit_idx <= '0;
         shreg   <= data;
      end else if (state == ST_IDLE) begin
         cnt <= '0;
      end else if (bit_end) begin
         cnt <= '0;
         if (state == ST_DATA) begin
            shreg   <= shreg >> 1;
            bit_idx <= bit_idx + 3'd1;
         end
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/nano_uart_monitor.sv
// rtl/nano_uart_monitor.sv - snapshots CPU debug taps and streams them as an 8-byte UART frame
module nano_uart_monitor
   import nano_uart_monitor_pkg::*;
#(
   parameter int         CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int         AUTO_PERIOD  = DEFAULT_AUTO_PERIOD,
   parameter logic [7:0] HEADER       = MON_HEADER
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        TRIG,
   input  logic        AUTO,
   input  logic [7:0]  STATE,
   input  logic [7:0]  FLAGS,
   input  logic [31:0] R,
   output logic        TX,
   output logic        BUSY,
   output logic        DONE
);

   localparam int            AW        = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
   localparam logic [AW-1:0] AUTO_LAST = AW'(AUTO_PERIOD - 1);

   logic [47:0]   snap;
   logic [7:0]    chk;
   logic [2:0]    idx;
   logic [2:0]    next_idx;
   logic          load_pend;
   logic          busy_q;
   logic          done_q;
   logic [AW-1:0] auto_cnt;
   logic          active;
   logic          start;
   logic          last_byte;
   logic          byte_done;
   logic          tx_load;
   logic [7:0]    tx_data;

   // load_pend covers the cycle between the start edge and the first start bit
   assign active    = busy_q | load_pend;
   assign start     = !active && (TRIG || (AUTO && (auto_cnt == AUTO_LAST)));
   assign last_byte = (idx == 3'(MON_FRAME_BYTES - 1));
   assign next_idx  = load_pend ? 3'd0 : idx + 3'd1;
   assign tx_load   = load_pend | (byte_done & !last_byte);

   always_comb begin
      tx_data = chk;
      case (next_idx)
         3'd0:    tx_data = HEADER;
         3'd1:    tx_data = snap[47:40];
         3'd2:    tx_data = snap[39:32];
         3'd3:    tx_data = snap[7:0];
         3'd4:    tx_data = snap[15:8];
         3'd5:    tx_data = snap[23:16];
         3'd6:    tx_data = snap[31:24];
         default: tx_data = chk;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         snap      <= '0;
         chk       <= '0;
         idx       <= '0;
         load_pend <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         auto_cnt  <= '0;
      end else begin
         done_q    <= 1'b0;
         load_pend <= start;
         if (start) begin
            snap <= {STATE, FLAGS, R};
            chk  <= frame_chk(STATE, FLAGS, R);
            idx  <= '0;
         end
         if (load_pend) begin
            busy_q <= 1'b1;
         end else if (byte_done) begin
            if (last_byte) begin
               busy_q <= 1'b0;
               done_q <= 1'b1;
            end else begin
               idx <= idx + 3'd1;
            end
         end
         if (active || !AUTO || start) begin
            auto_cnt <= '0;
         end else begin
            auto_cnt <= auto_cnt + AW'(1);
         end
      end
   end

   uart_tx_byte #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_tx (
      .CLK  (CLK),
      .RST  (RST),
      .load (tx_load),
      .data (tx_data),
      .tx   (TX),
      .done (byte_done)
   );

   assign BUSY = busy_q;
   assign DONE = done_q;

endmodule
